uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
Sequences 32-bit APB write words into the serial UART transmitter one byte at a time. Sits between the UART slave's APB write path and the UART TX core. A small word FIFO absorbs bursts. Byte lanes are selected by strobes and issued LSB-lane first using a start/done handshake with the TX core. Buffer-empty and error status are reported back to the slave for READY and interrupt generation.

Parameters:
DEPTH, 4, FIFO depth in 32-bit words; power of two, minimum 2.
ADDR_W, 2, log2(DEPTH).
TIMEOUT_CYCLES, 4096, cycles to wait for tx_done before aborting a byte; used only with the optional feature.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
wr_valid  in  1  write request from the APB slave; qualifies wr_data and wr_strb.
wr_data  in  32  word to transmit.
wr_strb  in  4  byte-lane enables; bit i enables wr_data[8i+7:8i].
wr_ready  out  1  FIFO can accept a word; a transfer occurs when wr_valid and wr_ready are both high.
tx_start  out  1  one-cycle pulse to the TX core: send tx_byte.
tx_byte  out  8  byte for the TX core; stable from tx_start until tx_done.
tx_done  in  1  one-cycle pulse from the TX core when the frame (stop bit) is complete.
fifo_level  out  ADDR_W+1  number of words currently stored.
idle  out  1  FIFO empty and FSM in IDLE.
err  out  1  sticky timeout flag; 0 when the optional feature is compiled out.

Behaviour:
- Reset values while rst is high, applied asynchronously:
  - wr_ready=1, tx_start=0, tx_byte=0, fifo_level=0, idle=1, err=0.
  - FIFO pointers cleared; FSM in IDLE.
  - A byte in flight is abandoned; the TX core is reset by its own reset.
- FIFO storage: 36 bits per entry (data plus strobes).
  - wr_ready = (fifo_level != DEPTH), computed from registered level.
  - When full, no push occurs even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full: level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, SEND, WAIT.
  - IDLE: if the FIFO is non-empty, pop the head word into the shift register (data and strb) and go to LOAD.
  - LOAD: find the lowest set bit of the remaining strb.
    - If none: go to IDLE. A word with strb=0 is consumed and transmits nothing.
    - Otherwise: drive tx_byte with that lane, clear that strb bit, pulse tx_start for one cycle, go to WAIT.
  - WAIT: hold tx_byte.
    - On tx_done: go to SEND.
  - SEND: if the remaining strb is non-zero, go to LOAD; otherwise go to IDLE.
- Lane order: always 0, 1, 2, 3, skipping disabled lanes.
- Latency: a word pushed at edge N into an empty FIFO with the FSM in IDLE is popped at N+1; tx_start is high during cycle N+2.
- Inter-byte gap after tx_done: tx_start pulses 2 cycles later (SEND then LOAD).
- A tx_done pulse outside WAIT is ignored.
- idle = (fifo_level==0) and (state==IDLE).

Optional Feature:
UART_TX_SCHED_TIMEOUT_EN.
- Compiled in:
  - A counter is cleared on entry to WAIT and increments each cycle in WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without tx_done: set err, discard the remaining lanes of the current word, go to IDLE.
  - err stays set until rst.
- Compiled out: no counter is built; err is tied to 0; WAIT waits indefinitely.

Decomposition:
- Package uart_tx_sched_pkg: FSM state encoding (2 bits), default DEPTH and TIMEOUT_CYCLES constants, lane-count constant 4.
- Sub-module sync_word_fifo (parameterised by width and depth): push, pop, full, empty, level.
- The scheduler FSM, lane selection and timeout stay in the top module.

Test Plan:
- Reset, then push 0x44332211 with strb=0xF, respond with tx_done 20 cycles after each start -> tx_byte sequence 0x11, 0x22, 0x33, 0x44; four tx_start pulses; idle=1 afterwards.
- Push 0xAABBCCDD with strb=0b1010 -> only 0xCC then 0xAA transmitted.
- Push strb=0 word followed by 0x000000EE with strb=0x1 -> the first word produces no tx_start; 0xEE is sent; fifo_level returns to 0.
- Hold off tx_done and push DEPTH+1 words back-to-back -> wr_ready=0 once fifo_level=4; the fifth word is accepted only after the first pop; no word is lost or duplicated.
- Assert rst while in WAIT with 3 words queued -> the same cycle shows tx_start=0 and fifo_level=0; after release, idle=1 and no tx_start occurs without new pushes.
- With UART_TX_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, never pulse tx_done -> err=1 after 16 WAIT cycles; remaining lanes are dropped; the next queued word starts normally.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART TX byte scheduler.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } sched_state_e;

    localparam int DEFAULT_DEPTH          = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;
    localparam int NUM_LANES              = 4;
    localparam int WORD_W                 = 32;
    localparam int ENTRY_W                = WORD_W + NUM_LANES;

    // Returns 0 for an empty mask; callers test the mask for zero first.
    function automatic logic [1:0] lowest_lane(input logic [NUM_LANES-1:0] strb);
        logic [1:0] lane;
        lane = 2'd0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (strb[i]) lane = 2'(i);
        end
        return lane;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Write-side and TX-core handshake bundle of the UART TX scheduler.
interface uart_tx_scheduler_if;
    import uart_tx_sched_pkg::*;

    logic                 wr_valid;
    logic [WORD_W-1:0]    wr_data;
    logic [NUM_LANES-1:0] wr_strb;
    logic                 wr_ready;
    logic                 tx_start;
    logic [7:0]           tx_byte;
    logic                 tx_done;

    modport master (
        output wr_valid, wr_data, wr_strb, tx_done,
        input  wr_ready, tx_start, tx_byte
    );

    modport slave (
        input  wr_valid, wr_data, wr_strb, tx_done,
        output wr_ready, tx_start, tx_byte
    );

endinterface

// File: rtl/uart_tx_scheduler_sync_word_fifo.sv
// Single-clock word FIFO; push is ignored when full, pop ignored when empty.
module sync_word_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Buffers strobed 32-bit words and feeds enabled byte lanes, lane 0 first, to the UART TX core.
// Define UART_TX_SCHED_TIMEOUT_EN to abort a byte whose tx_done never arrives and raise a sticky err.
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int DEPTH          = DEFAULT_DEPTH,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_scheduler_if.slave bus,
    output logic [ADDR_W:0]    fifo_level_o,
    output logic               idle_o,
    output logic               err_o
);

    sched_state_e         state_q, state_d;
    logic [WORD_W-1:0]    data_q, data_d;
    logic [NUM_LANES-1:0] strb_q, strb_d;
    logic [7:0]           tx_byte_q, tx_byte_d;

    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   fifo_rdata;

    logic [1:0]           lane;
    logic [7:0]           lane_byte;
    logic                 tx_start;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    sync_word_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.wr_valid),
        .pop_i   (fifo_pop),
        .wdata_i ({bus.wr_strb, bus.wr_data}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    assign lane      = lowest_lane(strb_q);
    assign lane_byte = data_q[{lane, 3'b000} +: 8];

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        strb_d    = strb_q;
        tx_byte_d = tx_byte_q;
        fifo_pop  = 1'b0;
        tx_start  = 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_d   = fifo_rdata[WORD_W-1:0];
                    strb_d   = fifo_rdata[ENTRY_W-1:WORD_W];
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // An all-zero strobe word is consumed here without any TX traffic.
                if (strb_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    tx_start  = 1'b1;
                    tx_byte_d = lane_byte;
                    strb_d    = strb_q & ~(4'b0001 << lane);
                    state_d   = ST_WAIT;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (bus.tx_done) begin
                    state_d = ST_SEND;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    strb_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            ST_SEND: begin
                state_d = (strb_q != '0) ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            strb_q    <= '0;
            tx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            tx_byte_q <= tx_byte_d;
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // The lane is shown combinationally during LOAD so the byte is valid alongside tx_start.
    assign bus.tx_byte  = tx_start ? lane_byte : tx_byte_q;
    assign bus.tx_start = tx_start;
    assign bus.wr_ready = !fifo_full;
    assign idle_o       = (fifo_level_o == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomised and directed bench for uart_tx_scheduler against a byte-queue reference model.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
    import uart_tx_sched_pkg::*;

    localparam int DEPTH      = 4;
    localparam int AW         = 2;
    localparam int TB_TIMEOUT = 16;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int DLY = 6;
`else
    localparam int DLY = 20;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_scheduler_if bus();
    logic [AW:0] fifo_level;
    logic        idle;
    logic        err;

    uart_tx_scheduler #(
        .DEPTH          (DEPTH),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .fifo_level_o (fifo_level),
        .idle_o       (idle),
        .err_o        (err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] req);
        chk(act === req, name, act, req);
    endtask

    // Reference model: bytes owed to the TX core in order, tagged with their word id.
    logic [7:0] exp_b[$];
    int         exp_w[$];
    int         word_id = 0;
    logic [7:0] start_log[$];
    int         start_cyc_log[$];

    bit         in_flight = 0;
    logic [7:0] inflight_b;
    int         inflight_w;
    int         start_cyc;
    bit         err_model = 0;
    bit         lat_pending = 0;
    bit         gap_pending = 0;
    int         lat_cyc;
    int         gap_cyc;
    int         cyc = 0;

    int resp_cnt   = 0;
    int done_delay = DLY;
    bit rand_mode  = 0;

    // TX core stand-in: answers each start after a delay, optionally adds stray pulses outside WAIT.
    always @(posedge clk) begin
        if (rst) resp_cnt = 0;
        else if (bus.tx_start && done_delay != 0)
            resp_cnt = rand_mode ? int'($urandom_range(8, 1)) : done_delay;
        else if (resp_cnt != 0) resp_cnt = resp_cnt - 1;
        else if (in_flight && done_delay != 0) resp_cnt = done_delay;
        #1;
        bus.tx_done = (resp_cnt == 1) ||
                      (rand_mode && !in_flight && resp_cnt == 0 && $urandom_range(7, 0) == 0);
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_b.delete();
            exp_w.delete();
            in_flight   = 0;
            err_model   = 0;
            lat_pending = 0;
            gap_pending = 0;
            chk_eq("rst_tx_start", bus.tx_start, 0);
            chk_eq("rst_tx_byte", bus.tx_byte, 0);
            chk_eq("rst_level", fifo_level, 0);
            chk_eq("rst_idle", idle, 1);
            chk_eq("rst_wr_ready", bus.wr_ready, 1);
            chk_eq("rst_err", err, 0);
        end else begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
            if (in_flight && (cyc - start_cyc) == TB_TIMEOUT + 1) begin
                err_model   = 1;
                in_flight   = 0;
                gap_pending = 0;
                while (exp_w.size() > 0 && exp_w[0] == inflight_w) begin
                    void'(exp_b.pop_front());
                    void'(exp_w.pop_front());
                end
            end
`endif
            chk_eq("err", err, err_model);
            chk_eq("wr_ready", bus.wr_ready, fifo_level != DEPTH);
            chk(fifo_level <= DEPTH, "level_range", fifo_level, DEPTH);
            if (idle) chk(exp_b.size() == 0 && !in_flight, "idle_drained", exp_b.size(), 0);
            if (bus.tx_start) begin
                chk(!in_flight, "start_while_busy", in_flight, 0);
                if (exp_b.size() == 0) begin
                    chk(0, "spurious_start", bus.tx_byte, 0);
                end else begin
                    chk_eq("tx_byte", bus.tx_byte, exp_b[0]);
                    inflight_b = exp_b.pop_front();
                    inflight_w = exp_w.pop_front();
                end
                if (lat_pending) chk_eq("first_latency", cyc - lat_cyc, 2);
                if (gap_pending) chk_eq("byte_gap", cyc - gap_cyc, 2);
                lat_pending = 0;
                gap_pending = 0;
                start_log.push_back(bus.tx_byte);
                start_cyc_log.push_back(cyc);
                in_flight = 1;
                start_cyc = cyc;
            end else if (in_flight) begin
                chk_eq("tx_byte_hold", bus.tx_byte, inflight_b);
                if (bus.tx_done) begin
                    in_flight = 0;
                    if (exp_w.size() > 0 && exp_w[0] == inflight_w) begin
                        gap_pending = 1;
                        gap_cyc     = cyc;
                    end
                end
            end
            if (bus.wr_valid && bus.wr_ready) begin
                if (idle && bus.wr_strb != 0) begin
                    lat_pending = 1;
                    lat_cyc     = cyc;
                end
                for (int j = 0; j < NUM_LANES; j++) begin
                    if (bus.wr_strb[j]) begin
                        exp_b.push_back(bus.wr_data[8*j +: 8]);
                        exp_w.push_back(word_id);
                    end
                end
                word_id++;
            end
        end
    end

    task automatic push_word(input logic [31:0] d, input logic [3:0] s);
        bit ok;
        ok = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        bus.wr_strb  = s;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.wr_ready && !rst) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk(0, "push_accept_timeout", d, 1);
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (idle && !in_flight && exp_b.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk(ok, {"drain_", name}, exp_b.size(), 0);
    endtask

    function automatic logic [31:0] t4_word(input int k);
        return {8'(16*k + 3), 8'(16*k + 2), 8'(16*k + 1), 8'(16*k)};
    endfunction

    int base;

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.wr_strb  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Full word, lanes in order 0..3.
        done_delay = DLY;
        base = start_log.size();
        push_word(32'h44332211, 4'hF);
        drain(400, "t1");
        chk_eq("t1_count", start_log.size() - base, 4);
        if (start_log.size() - base == 4) begin
            chk_eq("t1_b0", start_log[base], 8'h11);
            chk_eq("t1_b1", start_log[base+1], 8'h22);
            chk_eq("t1_b2", start_log[base+2], 8'h33);
            chk_eq("t1_b3", start_log[base+3], 8'h44);
            chk_eq("t1_gap", start_cyc_log[base+1] - start_cyc_log[base], DLY + 2);
        end
        chk_eq("t1_idle", idle, 1);

        // Sparse strobes.
        base = start_log.size();
        push_word(32'hAABBCCDD, 4'b1010);
        drain(400, "t2");
        chk_eq("t2_count", start_log.size() - base, 2);
        if (start_log.size() - base == 2) begin
            chk_eq("t2_b0", start_log[base], 8'hCC);
            chk_eq("t2_b1", start_log[base+1], 8'hAA);
        end

        // Empty-strobe word is consumed silently.
        base = start_log.size();
        push_word(32'h12345678, 4'h0);
        push_word(32'h000000EE, 4'h1);
        drain(400, "t3");
        chk_eq("t3_count", start_log.size() - base, 1);
        if (start_log.size() - base == 1) chk_eq("t3_b0", start_log[base], 8'hEE);
        chk_eq("t3_level", fifo_level, 0);

        // Back-pressure: one word in flight plus a full FIFO.
        done_delay = 0;
        base = start_log.size();
        for (int k = 1; k <= 5; k++) push_word(t4_word(k), 4'hF);
        chk_eq("t4_full_level", fifo_level, 4);
        chk_eq("t4_full_ready", bus.wr_ready, 0);
        bus.wr_valid = 1'b1;
        bus.wr_data  = t4_word(6);
        bus.wr_strb  = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("t4_stall_ready", bus.wr_ready, 0);
        chk_eq("t4_stall_level", fifo_level, 4);
        done_delay = DLY;
        push_word(t4_word(6), 4'hF);
        drain(2000, "t4");
        chk_eq("t4_count", start_log.size() - base, 24);
        if (start_log.size() - base == 24) begin
            for (int i = 0; i < 24; i++)
                chk_eq("t4_order", start_log[base+i], 8'(16*(i/4 + 1) + i%4));
        end

        // Asynchronous reset while waiting for tx_done with three words queued.
        done_delay = 0;
        for (int k = 1; k <= 4; k++) push_word(32'hC0C0C0C0 + k, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        chk_eq("t5_pre_level", fifo_level, 3);
        chk_eq("t5_pre_busy", in_flight, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_eq("t5_rst_start", bus.tx_start, 0);
        chk_eq("t5_rst_level", fifo_level, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_delay = DLY;
        base = start_log.size();
        repeat (30) @(posedge clk);
        #1;
        chk_eq("t5_no_start", start_log.size() - base, 0);
        chk_eq("t5_idle", idle, 1);

        // Random traffic with random response delays and stray tx_done pulses.
        rand_mode  = 1;
        done_delay = 1;
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(3, 0)) @(posedge clk);
            #0;
            push_word($urandom, 4'($urandom));
        end
        drain(5000, "rand");
        rand_mode  = 0;
        done_delay = DLY;
        repeat (4) @(posedge clk);
        #1;

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Unanswered byte aborts its word; the next word proceeds.
        done_delay = 0;
        base = start_log.size();
        push_word(32'h55443322, 4'hF);
        push_word(32'h00000077, 4'h1);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 80; i++) begin
                @(posedge clk);
                #1;
                if (err) begin
                    seen = 1;
                    break;
                end
            end
            chk_eq("t6_err_seen", seen, 1);
        end
        done_delay = DLY;
        drain(400, "t6");
        chk_eq("t6_count", start_log.size() - base, 2);
        if (start_log.size() - base == 2) begin
            chk_eq("t6_b0", start_log[base], 8'h22);
            chk_eq("t6_b1", start_log[base+1], 8'h77);
            chk_eq("t6_restart", start_cyc_log[base+1] - start_cyc_log[base], TB_TIMEOUT + 2);
        end
        chk_eq("t6_err_sticky", err, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
